avg_result_collector: RTL and testbench

//  Consumer side of the averager output stream: captures each (valid, out) result byte into a frame buffer.

---
 rtl/avg_result_collector.sv | 84 ++++++++
 tb/tb_avg_result_collector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/avg_result_collector.sv
// avg_result_collector: buffers one frame of averager results, then drains it over valid/ready with checksum and status.
module avg_result_collector #(
    parameter int DW    = 8,
    parameter int DEPTH = 120,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          clear,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          frame_done,
    output logic [15:0]   checksum,
    output logic [7:0]    frame_cnt,
    output logic          overflow
);

    typedef enum logic [1:0] {COLLECT, LOAD, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, wr_last, xfer, xfer_last;

    always_comb begin
        wr_en     = (state == COLLECT) && in_valid;
        wr_last   = wr_en && (wr_ptr == AW'(DEPTH - 1));
        xfer      = (state == DRAIN) && rd_valid && rd_ready;
        xfer_last = xfer && rd_last;
        state_nxt = (state == COLLECT) ? (wr_last ? LOAD : COLLECT) :
                    (state == LOAD)    ? DRAIN :
                    (xfer_last ? COLLECT : DRAIN);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= COLLECT;
        else        state <= state_nxt;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            frame_done <= 1'b0;
            checksum   <= '0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= wr_last;
            if (wr_en) begin
                checksum <= checksum + 16'(in_data);
                wr_ptr   <= wr_last ? '0 : wr_ptr + 1'b1;
            end
            if (state == LOAD) begin
                rd_data  <= mem[0];
                rd_valid <= 1'b1;
                rd_last  <= (DEPTH == 1);
                rd_ptr   <= AW'(1);
            end else if (xfer_last) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                rd_ptr   <= '0;
                checksum <= '0;
            end else if (xfer && ({1'b0, rd_ptr} < (AW+1)'(DEPTH))) begin
                rd_data <= mem[rd_ptr];
                rd_last <= (rd_ptr == AW'(DEPTH - 1));
                rd_ptr  <= rd_ptr + 1'b1;
            end
            // Bytes arriving outside COLLECT are dropped; clear beats a same-cycle set/increment
            overflow  <= clear ? 1'b0 : (overflow | (in_valid && state != COLLECT));
            frame_cnt <= clear ? '0 : frame_cnt + 8'(xfer_last);
        end
    end

endmodule

// File: tb/tb_avg_result_collector.sv
// tb_avg_result_collector: scoreboard bench for avg_result_collector; expected bytes queued on write, checked on drain.
module tb_avg_result_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 120;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          clear = 1'b0;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          frame_done;
    logic [15:0]   checksum;
    logic [7:0]    frame_cnt;
    logic          overflow;

    int         checks = 0;
    int         failures = 0;
    int         fd_seen = 0;
    int         exp_fd = 0;
    int         cur_sum = 0;
    logic [7:0] exp_cnt = '0;
    bit         toggle_mode = 1'b0;
    logic [8:0] q[$];

    avg_result_collector #(.DW(DW), .DEPTH(DEPTH), .AW(7)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .frame_done(frame_done), .checksum(checksum), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // mode: 0 ramp, 1 all 0xFF, 2 random with gaps, 3 i*3+1, 4 random back-to-back
    task automatic send_frame(input int mode);
        int sum = 0;
        logic [7:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            d = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hFF : (mode == 3) ? 8'(i * 3 + 1) : 8'($urandom);
            in_valid = 1'b1;
            in_data = d;
            q.push_back({1'(i == DEPTH - 1), d});
            sum += int'(d);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("frame_done", frame_done, 1);
        chk("checksum", checksum, 16'(sum));
        chk("load_rd_valid", rd_valid, 0);
        @(negedge clk);
        #2;
        chk("frame_done_pulse", frame_done, 0);
        chk("first_valid", rd_valid, 1);
        chk("checksum_hold", checksum, 16'(sum));
        exp_fd++;
        chk("fd_count", fd_seen, exp_fd);
        cur_sum = sum;
    endtask

    task automatic wait_drain(input int exp_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((q.size() != 0 || rd_valid) && n < 1000);
        chk("drained", q.size(), 0);
        chk("rd_valid_idle", rd_valid, 0);
        if (exp_cycles >= 0) chk("drain_cycles", n, exp_cycles);
        chk("frame_cnt", frame_cnt, exp_cnt);
    endtask

    initial begin
        rd_ready = 1'b1;
        forever begin
            @(negedge clk);
            rd_ready = toggle_mode ? ~rd_ready : 1'b1;
        end
    end

    // Every cycle with rd_valid must present the scoreboard head, held until rd_ready takes it
    initial forever begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (frame_done) fd_seen++;
            if (rd_valid) begin
                if (q.size() == 0) chk("spurious_valid", rd_valid, 0);
                else begin
                    chk("rd_data", rd_data, q[0][7:0]);
                    chk("rd_last", rd_last, q[0][8]);
                    if (rd_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // T1 reset and idle
        repeat (3) @(negedge clk);
        #2;
        chk_idle("t1");
        @(negedge clk);
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #2;
            chk("t1_idle_valid", rd_valid, 0);
        end
        // T2 ramp, always ready
        send_frame(0);
        chk("t2_sum_const", checksum, 16'h1BE4);
        exp_cnt++;
        wait_drain(DEPTH);
        chk("t2_overflow", overflow, 0);
        // T3 0xFF with toggling ready
        toggle_mode = 1'b1;
        send_frame(1);
        chk("t3_sum_const", checksum, 16'h7788);
        exp_cnt++;
        wait_drain(-1);
        toggle_mode = 1'b0;
        chk("t3_overflow", overflow, 0);
        // T4 stray bytes during drain and on the final transfer
        send_frame(3);
        for (int c = 1; c < DEPTH; c++) begin
            @(negedge clk);
            in_valid = (c >= 10 && c < 15) || c == DEPTH - 1;
            in_data = 8'hAA;
            if (c == 16) begin
                #2;
                chk("t4_overflow_set", overflow, 1);
                chk("t4_checksum_hold", checksum, 16'(cur_sum));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp_cnt++;
        wait_drain(-1);
        chk("t4_checksum_zero", checksum, 0);
        chk("t4_overflow_sticky", overflow, 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #2;
        chk("t4_clear_ovf", overflow, 0);
        chk("t4_clear_cnt", frame_cnt, 0);
        exp_cnt = '0;
        // clear coincident with the final transfer wins over the increment
        send_frame(0);
        for (int c = 1; c < DEPTH; c++) begin
            @(negedge clk);
            clear = (c == DEPTH - 1);
        end
        @(negedge clk);
        clear = 1'b0;
        wait_drain(-1);
        chk("t4b_overflow", overflow, 0);
        // T5 reset mid-frame and mid-drain
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'(i + 50);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 reset = 1'b0;
        #1 chk_idle("t5a");
        @(negedge clk);
        reset = 1'b1;
        send_frame(3);
        repeat (30) @(negedge clk);
        #3 reset = 1'b0;
        #1 chk_idle("t5b");
        q.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset = 1'b1;
        send_frame(2);
        exp_cnt++;
        wait_drain(-1);
        // T6 257 frames, counter wraps
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_cnt = '0;
        for (int f = 0; f < 257; f++) begin
            send_frame(4);
            exp_cnt++;
            wait_drain(DEPTH);
        end
        chk("t6_wrap", frame_cnt, 1);
        chk("t6_overflow", overflow, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
